// File: rtl/vector_apply_seq.sv
// Vector sequencer: applies a loadable table of stimulus vectors to a DUT,
// holds each one for HOLD cycles, and folds every sampled y into a signature.
module vector_apply_seq #(
  parameter int IN_W  = 83,
  parameter int OUT_W = 245,
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int HOLD  = 2,
  parameter int SIG_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_we,
  input  logic [AW-1:0]     load_addr,
  input  logic [IN_W-1:0]   load_data,
  input  logic [AW:0]       num_vec,
  input  logic              start,
  output logic [IN_W-1:0]   dut_in,
  input  logic [OUT_W-1:0]  dut_y,
  output logic              busy,
  output logic              cap_valid,
  output logic [AW-1:0]     vec_idx,
  output logic              done,
  output logic [SIG_W-1:0]  sig
);

  localparam int HW  = $clog2(HOLD + 1);
  localparam int NSL = (OUT_W + SIG_W - 1) / SIG_W;
  localparam logic [AW:0] DEPTH_N = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_CAPTURE, S_FIN} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     vec_idx_q, vec_idx_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic              busy_q, busy_d;
  logic [SIG_W-1:0]  sig_q, sig_d;
  logic [AW:0]       n_q, n_d;
  logic [IN_W-1:0]   dut_in_q;
  logic [IN_W-1:0]   tbl_mem [DEPTH];

  logic                  wr_en;
  logic                  ld_vec;
  logic                  bypass;
  logic [AW-1:0]         rd_addr;
  logic [AW:0]           n_in;
  logic                  last_vec;
  logic [NSL*SIG_W-1:0]  y_pad;
  logic [SIG_W-1:0]      fold;

  assign wr_en    = load_we & ~busy_q;
  assign n_in     = (num_vec > DEPTH_N) ? DEPTH_N : num_vec;
  assign last_vec = ({1'b0, vec_idx_q} == (n_q - 1'b1));
  // Write-first: a vector fetched in the same cycle as its own write sees the new data.
  assign bypass   = wr_en && (load_addr == rd_addr);

  always_comb begin
    y_pad = '0;
    y_pad[OUT_W-1:0] = dut_y;
    fold = '0;
    for (int k = 0; k < NSL; k++) begin
      fold = fold ^ y_pad[k*SIG_W +: SIG_W];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tbl_mem[load_addr] <= load_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    vec_idx_d = vec_idx_q;
    hold_d    = hold_q;
    busy_d    = busy_q;
    sig_d     = sig_q;
    n_d       = n_q;
    ld_vec    = 1'b0;
    rd_addr   = vec_idx_q + 1'b1;
    cap_valid = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d   = n_in;
          sig_d = '0;
          if (n_in != '0) begin
            state_d   = S_APPLY;
            vec_idx_d = '0;
            hold_d    = '0;
            busy_d    = 1'b1;
            ld_vec    = 1'b1;
            rd_addr   = '0;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_APPLY: begin
        hold_d = hold_q + 1'b1;
        if (hold_q == HW'(HOLD - 1)) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        cap_valid = 1'b1;
        sig_d     = {sig_q[SIG_W-2:0], sig_q[SIG_W-1]} ^ fold;
        if (last_vec) begin
          state_d = S_FIN;
        end else begin
          vec_idx_d = vec_idx_q + 1'b1;
          hold_d    = '0;
          ld_vec    = 1'b1;
          state_d   = S_APPLY;
        end
      end
      S_FIN: begin
        done    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      vec_idx_q <= '0;
      hold_q    <= '0;
      busy_q    <= 1'b0;
      sig_q     <= '0;
      n_q       <= '0;
    end else begin
      state_q   <= state_d;
      vec_idx_q <= vec_idx_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      sig_q     <= sig_d;
      n_q       <= n_d;
    end
  end

  // Table read lands directly in the drive register; it only moves when a vector is fetched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dut_in_q <= '0;
    end else if (ld_vec) begin
      dut_in_q <= bypass ? load_data : tbl_mem[rd_addr];
    end
  end

  assign dut_in  = dut_in_q;
  assign busy    = busy_q;
  assign vec_idx = vec_idx_q;
  assign sig     = sig_q;

endmodule
